// File: rtl/banco_registradores_sb.sv
// banco_registradores_sb
// ----------------------
// This is a register file with a scoreboard. It holds NUM_REGS registers of
// LARGURA bits. Each register also has a busy bit that marks it as the
// destination of an in-flight producer.
//
// Reads are combinational. A write that happens in the same cycle is
// bypassed to the read ports. A reservation of a register that is already
// busy is flagged on erroReserva for one cycle.
//
// Parameters
//   LARGURA   data width of each register
//   NUM_REGS  register count (power of two, >= 2)
//   ZERO_REG  when 1, register 0 is hardwired to zero and is never busy
//
// Ports
//   Clock, Reset                  rising-edge clock, async active-high reset
//   regWrite/regEscrita/DadosEscrita   write enable, address and data
//   reserva/regReserva            reserve (mark busy) enable and address
//   regLeitura1/2                 read addresses
//   DadosLeitura1/2               read data (with write bypass)
//   ocupado1/2                    read register has a pending producer
//   erroReserva                   registered reservation-conflict flag
module banco_registradores_sb #(
    parameter int LARGURA  = 32,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    localparam int END_W   = $clog2(NUM_REGS)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               regWrite,
    input  logic [END_W-1:0]   regEscrita,
    input  logic [LARGURA-1:0] DadosEscrita,
    input  logic               reserva,
    input  logic [END_W-1:0]   regReserva,
    input  logic [END_W-1:0]   regLeitura1,
    input  logic [END_W-1:0]   regLeitura2,
    output logic [LARGURA-1:0] DadosLeitura1,
    output logic [LARGURA-1:0] DadosLeitura2,
    output logic               ocupado1,
    output logic               ocupado2,
    output logic               erroReserva
);

    logic [LARGURA-1:0] registradores [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                erro_reg;

    // One-hot decode of the write and reserve targets. Register 0 is masked
    // out of both vectors when it is hardwired, so it can never change state.
    logic [NUM_REGS-1:0] write_hit;
    logic [NUM_REGS-1:0] reserve_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            localparam bit PROTEGIDO = (ZERO_REG != 0) && (gi == 0);
            assign write_hit[gi]   = regWrite && (regEscrita == END_W'(gi)) && !PROTEGIDO;
            assign reserve_hit[gi] = reserva  && (regReserva == END_W'(gi)) && !PROTEGIDO;
        end
    endgenerate

    // There is a conflict only when the reserved register stays busy through
    // the edge. A write that completes on the same edge retires the old
    // producer, so the new reservation is legitimate.
    logic erro_next;
    assign erro_next = |(reserve_hit & busy & ~write_hit);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registradores[i] <= '0;
            end
            busy     <= '0;
            erro_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (write_hit[i]) begin
                    registradores[i] <= DadosEscrita;
                end
                // The reservation takes priority, because a new producer
                // replaces the one that is completing.
                if (reserve_hit[i]) begin
                    busy[i] <= 1'b1;
                end else if (write_hit[i]) begin
                    busy[i] <= 1'b0;
                end
            end
            erro_reg <= erro_next;
        end
    end

    assign erroReserva = erro_reg;

    // Read port 1
    logic zero1;
    logic bypass1;
    assign zero1   = (ZERO_REG != 0) && (regLeitura1 == '0);
    assign bypass1 = regWrite && (regEscrita == regLeitura1);

    always_comb begin
        DadosLeitura1 = registradores[regLeitura1];
        ocupado1      = busy[regLeitura1] && !bypass1;
        if (zero1) begin
            DadosLeitura1 = '0;
            ocupado1      = 1'b0;
        end else if (bypass1) begin
            DadosLeitura1 = DadosEscrita;
        end
    end

    // Read port 2 (independent of port 1)
    logic zero2;
    logic bypass2;
    assign zero2   = (ZERO_REG != 0) && (regLeitura2 == '0);
    assign bypass2 = regWrite && (regEscrita == regLeitura2);

    always_comb begin
        DadosLeitura2 = registradores[regLeitura2];
        ocupado2      = busy[regLeitura2] && !bypass2;
        if (zero2) begin
            DadosLeitura2 = '0;
            ocupado2      = 1'b0;
        end else if (bypass2) begin
            DadosLeitura2 = DadosEscrita;
        end
    end

endmodule

// File: tb/tb_banco_registradores_sb.sv
// Directed testbench for banco_registradores_sb.
// It uses two instances: one with the default parameters, and one with
// LARGURA=16, NUM_REGS=8 and ZERO_REG=0.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1 time unit later, well away from the next edge.
module tb_banco_registradores_sb;

    logic        clk = 1'b0;
    logic        rst;

    // Default instance (32 x 32, reg 0 hardwired)
    logic        rw;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        resv;
    logic [4:0]  raddr_resv;
    logic [4:0]  rl1, rl2;
    logic [31:0] dl1, dl2;
    logic        oc1, oc2, erro;

    // Small instance (8 x 16, reg 0 writable)
    logic        p_rw;
    logic [2:0]  p_waddr;
    logic [15:0] p_wdata;
    logic        p_resv;
    logic [2:0]  p_raddr_resv;
    logic [2:0]  p_rl1, p_rl2;
    logic [15:0] p_dl1, p_dl2;
    logic        p_oc1, p_oc2, p_erro;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    banco_registradores_sb dut (
        .Clock(clk), .Reset(rst),
        .regWrite(rw), .regEscrita(waddr), .DadosEscrita(wdata),
        .reserva(resv), .regReserva(raddr_resv),
        .regLeitura1(rl1), .regLeitura2(rl2),
        .DadosLeitura1(dl1), .DadosLeitura2(dl2),
        .ocupado1(oc1), .ocupado2(oc2), .erroReserva(erro)
    );

    banco_registradores_sb #(.LARGURA(16), .NUM_REGS(8), .ZERO_REG(0)) dut_p (
        .Clock(clk), .Reset(rst),
        .regWrite(p_rw), .regEscrita(p_waddr), .DadosEscrita(p_wdata),
        .reserva(p_resv), .regReserva(p_raddr_resv),
        .regLeitura1(p_rl1), .regLeitura2(p_rl2),
        .DadosLeitura1(p_dl1), .DadosLeitura2(p_dl2),
        .ocupado1(p_oc1), .ocupado2(p_oc2), .erroReserva(p_erro)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        rw = 0; resv = 0; p_rw = 0; p_resv = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        waddr = 0; wdata = 0; raddr_resv = 0; rl1 = 5; rl2 = 31;
        p_waddr = 0; p_wdata = 0; p_raddr_resv = 0; p_rl1 = 0; p_rl2 = 7;
        #2;
        chk32("reset_dl1", dl1, 32'h0);
        chk32("reset_dl2", dl2, 32'h0);
        chk32("reset_oc", {30'd0, oc1, oc2}, 32'h0);
        chk32("reset_erro", {31'd0, erro}, 32'h0);
        chk32("reset_p_dl1", {16'd0, p_dl1}, 32'h0);
        tick(); tick();
        rst = 0;
        #1;
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        rw = 1; waddr = 5; wdata = 32'hDEADBEEF; rl1 = 5; rl2 = 5;
        #1;
        chk32("wr_bypass_dl1", dl1, 32'hDEADBEEF);
        chk32("wr_bypass_dl2", dl2, 32'hDEADBEEF);
        tick();
        rw = 0; wdata = 32'h0;
        #1;
        chk32("wr_stored_dl1", dl1, 32'hDEADBEEF);
        chk32("wr_stored_oc1", {31'd0, oc1}, 32'h0);
        rl2 = 6;
        #1;
        chk32("wr_other_reg_dl2", dl2, 32'h0);
        $display("test_write_read done");
    endtask

    task automatic test_reg0();
        tick();
        rw = 1; waddr = 0; wdata = 32'h12345678; resv = 1; raddr_resv = 0; rl1 = 0;
        #1;
        chk32("reg0_bypass_dl1", dl1, 32'h0);
        chk32("reg0_bypass_oc1", {31'd0, oc1}, 32'h0);
        tick();
        // Reserving reg 0 again must not raise a conflict either.
        #1;
        tick();
        idle();
        #1;
        chk32("reg0_dl1", dl1, 32'h0);
        chk32("reg0_oc1", {31'd0, oc1}, 32'h0);
        chk32("reg0_erro", {31'd0, erro}, 32'h0);
        $display("test_reg0 done");
    endtask

    task automatic test_scoreboard();
        tick();
        resv = 1; raddr_resv = 7; rl2 = 7;
        tick();
        resv = 0;
        #1;
        chk32("sb_busy_oc2", {31'd0, oc2}, 32'h1);
        chk32("sb_first_erro", {31'd0, erro}, 32'h0);
        rw = 1; waddr = 7; wdata = 32'h000000A5;
        #1;
        chk32("sb_unstall_oc2", {31'd0, oc2}, 32'h0);
        chk32("sb_bypass_dl2", dl2, 32'h000000A5);
        tick();
        rw = 0;
        #1;
        chk32("sb_cleared_oc2", {31'd0, oc2}, 32'h0);
        chk32("sb_stored_dl2", dl2, 32'h000000A5);
        $display("test_scoreboard done");
    endtask

    task automatic test_simultaneous();
        tick();
        resv = 1; raddr_resv = 3; rl1 = 3;
        tick();
        chk32("sim_first_resv_erro", {31'd0, erro}, 32'h0);
        // Second reservation while reg 3 is still busy.
        tick();
        resv = 0;
        #1;
        chk32("sim_conflict_erro", {31'd0, erro}, 32'h1);
        chk32("sim_conflict_oc1", {31'd0, oc1}, 32'h1);
        tick();
        chk32("sim_erro_one_cycle", {31'd0, erro}, 32'h0);
        // Reserve and write reg 3 on the same edge: the producer retires, so there is no conflict.
        resv = 1; raddr_resv = 3; rw = 1; waddr = 3; wdata = 32'h33;
        tick();
        idle();
        #1;
        chk32("sim_retire_erro", {31'd0, erro}, 32'h0);
        chk32("sim_retire_oc1", {31'd0, oc1}, 32'h1);
        // Reserve and write reg 4 on the same edge: the write lands and the register stays busy.
        resv = 1; raddr_resv = 4; rw = 1; waddr = 4; wdata = 32'h44; rl1 = 4;
        tick();
        idle();
        #1;
        chk32("sim_rw4_dl1", dl1, 32'h44);
        chk32("sim_rw4_oc1", {31'd0, oc1}, 32'h1);
        chk32("sim_rw4_erro", {31'd0, erro}, 32'h0);
        $display("test_simultaneous done");
    endtask

    task automatic test_async_reset();
        tick();
        rw = 1; waddr = 2; wdata = 32'h22; resv = 1; raddr_resv = 2;
        tick();
        waddr = 9; wdata = 32'h99; resv = 1; raddr_resv = 9;
        tick();
        idle();
        rl1 = 2; rl2 = 9;
        #1;
        chk32("ar_pre_dl1", dl1, 32'h22);
        chk32("ar_pre_dl2", dl2, 32'h99);
        chk32("ar_pre_oc", {30'd0, oc1, oc2}, 32'h3);
        // Pulse reset between edges and check without any clock edge.
        #1 rst = 1;
        #1;
        chk32("ar_now_dl1", dl1, 32'h0);
        chk32("ar_now_dl2", dl2, 32'h0);
        chk32("ar_now_oc", {30'd0, oc1, oc2}, 32'h0);
        // Writes and reservations are ignored on an edge while reset is held.
        rw = 1; waddr = 9; wdata = 32'h77; resv = 1; raddr_resv = 9;
        tick();
        idle();
        rst = 0;
        #1;
        chk32("ar_ignored_dl2", dl2, 32'h0);
        chk32("ar_ignored_oc2", {31'd0, oc2}, 32'h0);
        tick();
        chk32("ar_after_dl1", dl1, 32'h0);
        $display("test_async_reset done");
    endtask

    task automatic test_params();
        tick();
        p_rw = 1; p_waddr = 0; p_wdata = 16'hBEEF; p_rl1 = 0;
        #1;
        chk32("p_reg0_bypass", {16'd0, p_dl1}, 32'hBEEF);
        tick();
        p_rw = 1; p_waddr = 7; p_wdata = 16'h1234; p_rl2 = 7;
        p_resv = 1; p_raddr_resv = 0;
        tick();
        idle();
        #1;
        chk32("p_reg0_stored", {16'd0, p_dl1}, 32'hBEEF);
        chk32("p_reg7_stored", {16'd0, p_dl2}, 32'h1234);
        chk32("p_reg0_busy", {31'd0, p_oc1}, 32'h1);
        p_resv = 1; p_raddr_resv = 0;
        tick();
        p_resv = 0;
        #1;
        chk32("p_reg0_conflict", {31'd0, p_erro}, 32'h1);
        $display("test_params done");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg0();
        test_scoreboard();
        test_simultaneous();
        test_async_reset();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_registradores_sb.md
BANCO_REGISTRADORES_SB -- requirements
Module: banco_registradores_sb

Interface
REQ-001 SHALL have parameter LARGURA, default 32: data width of every register, in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count; it is a power of two, at least 2.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes and reservations.
REQ-004 SHALL use derived localparam END_W = clog2(NUM_REGS) for all address widths.
REQ-005 SHALL have port Clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port regWrite, input, 1 bit: write enable.
REQ-008 SHALL have port regEscrita, input, END_W bits: write address.
REQ-009 SHALL have port DadosEscrita, input, LARGURA bits: write data.
REQ-010 SHALL have port reserva, input, 1 bit: reserve enable, i.e. mark a destination as pending.
REQ-011 SHALL have port regReserva, input, END_W bits: reserve address.
REQ-012 SHALL have ports regLeitura1 and regLeitura2, input, END_W bits each: read addresses.
REQ-013 SHALL have ports DadosLeitura1 and DadosLeitura2, output, LARGURA bits each: read data.
REQ-014 SHALL have ports ocupado1 and ocupado2, output, 1 bit each: the read register has a pending write.
REQ-015 SHALL have port erroReserva, output, 1 bit, registered: reservation conflict flag.

Function
REQ-016 SHALL hold NUM_REGS data registers of LARGURA bits plus NUM_REGS busy bits.
REQ-017 SHALL, on a rising edge with regWrite=1, load DadosEscrita into register regEscrita, except register 0 when ZERO_REG=1.
REQ-018 SHALL, on the same edge as REQ-017, clear the busy bit of regEscrita.
REQ-019 SHALL, on a rising edge with reserva=1, set the busy bit of regReserva, except register 0 when ZERO_REG=1.
REQ-020 SHALL, when regWrite and reserva target the same register on the same edge, perform the data write and leave the busy bit set (reserve wins: new producer).
REQ-021 SHALL, when reserva targets a register whose busy bit is already set and that register is not cleared on the same edge, still keep it busy and raise erroReserva for exactly one cycle after that edge.
REQ-022 SHALL hold erroReserva at 0 in every other cycle.
REQ-023 SHALL make reads combinational with zero latency: DadosLeituraN = registradores[regLeituraN].
REQ-024 SHALL apply write bypass: if regWrite=1, regEscrita = regLeituraN and the register is writable, DadosLeituraN SHALL equal DadosEscrita in the same cycle.
REQ-025 SHALL drive DadosLeituraN = 0 and ocupadoN = 0 when regLeituraN = 0 and ZERO_REG=1, regardless of bypass.
REQ-026 SHALL drive ocupadoN = busy[regLeituraN] AND NOT (regWrite AND regEscrita = regLeituraN), so that a completing write un-stalls in the same cycle.
REQ-027 SHALL have both read ports fully independent, with identical addresses allowed.
REQ-028 SHALL accept a write to a non-busy register normally and leave busy at 0.
REQ-029 SHALL use no storage other than the data array, the busy vector and the erroReserva flop.

Reset
REQ-030 SHALL, while Reset=1, clear all data registers, all busy bits and erroReserva to 0 immediately, independent of Clock.
REQ-031 SHALL ignore regWrite and reserva on any edge while Reset=1; outputs SHALL then reflect zeroed state (bypass still combinational).
REQ-032 SHALL resume normal operation on the first rising edge after Reset deasserts; Reset mid-reservation SHALL discard all pending busy bits.

Verification
REQ-033 SHALL be verified for write then read: regWrite=1, regEscrita=5, DadosEscrita=0xDEADBEEF -> same cycle DadosLeitura1=0xDEADBEEF when regLeitura1=5 (bypass); after the edge with regWrite=0, still 0xDEADBEEF.
REQ-034 SHALL be verified for register 0: write 0x12345678 to reg 0 and reserve reg 0 -> DadosLeitura1=0, ocupado1=0, erroReserva=0.
REQ-035 SHALL be verified for scoreboard: reserve reg 7 -> next cycle ocupado2=1 for regLeitura2=7; regWrite reg 7 = 0xA5 -> ocupado2=0 that cycle and DadosLeitura2=0xA5; after the edge, busy clear.
REQ-036 SHALL be verified for simultaneous events: reserve reg 3 twice without a write -> erroReserva=1 for exactly one cycle; reserve and write reg 4 on the same edge -> data written, ocupado=1 afterwards.
REQ-037 SHALL be verified for async reset: registers loaded and regs 2 and 9 busy, Reset pulsed between edges -> all DadosLeitura=0, ocupado=0 immediately.
REQ-038 SHALL be verified for parameters: LARGURA=16, NUM_REGS=8, ZERO_REG=0 -> reg 0 writable (write 0xBEEF, read 0xBEEF); all addresses 3 bits.
